// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state, opcode and requester encodings for the memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RELEASE, DONE} state_e;
    typedef enum logic [1:0] {REQ_NONE, REQ_IC, REQ_DC} req_e;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin pick; on a tie the side not granted last wins
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    always_comb grant = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between icache and dcache, round-robin
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_SIZE     = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ic_enable,
    input  logic                     ic_op,
    input  logic [ADDRESS_WIDTH-1:0] ic_address,
    input  logic [LINE_SIZE-1:0]     ic_data_in,
    output logic [LINE_SIZE-1:0]     ic_data_out,
    output logic                     ic_data_ready,
    output logic                     ic_in_use,
    input  logic                     dc_enable,
    input  logic                     dc_op,
    input  logic [ADDRESS_WIDTH-1:0] dc_address,
    input  logic [LINE_SIZE-1:0]     dc_data_in,
    output logic [LINE_SIZE-1:0]     dc_data_out,
    output logic                     dc_data_ready,
    output logic                     dc_in_use,
    output logic                     mem_enable,
    output logic                     mem_op,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [LINE_SIZE-1:0]     mem_data_in,
    output logic                     mem_op_done,
    input  logic                     mem_data_ready,
    input  logic [LINE_SIZE-1:0]     mem_data_out
);
    state_e                   state_q, state_d;
    req_e                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic                     mem_enable_q, mem_enable_d;
    logic                     mem_op_q, mem_op_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [LINE_SIZE-1:0]     mem_data_in_q, mem_data_in_d;
    logic                     mem_op_done_q, mem_op_done_d;
    logic [LINE_SIZE-1:0]     ic_data_out_q, ic_data_out_d, dc_data_out_q, dc_data_out_d;
    logic                     ic_data_ready_q, ic_data_ready_d, dc_data_ready_q, dc_data_ready_d;
    logic [1:0]               grant;
    logic                     owner_en;

    // last_q: 0 = icache granted last, 1 = dcache granted last
    rr_arbiter2 u_rr (
        .req        ({dc_enable, ic_enable}),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign owner_en = (owner_q == REQ_IC) ? ic_enable : dc_enable;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        mem_enable_d    = mem_enable_q;
        mem_op_d        = mem_op_q;
        mem_address_d   = mem_address_q;
        mem_data_in_d   = mem_data_in_q;
        mem_op_done_d   = mem_op_done_q;
        ic_data_out_d   = ic_data_out_q;
        dc_data_out_d   = dc_data_out_q;
        ic_data_ready_d = ic_data_ready_q;
        dc_data_ready_d = dc_data_ready_q;
        case (state_q)
            IDLE: if (|grant) begin
                owner_d       = grant[0] ? REQ_IC : REQ_DC;
                mem_enable_d  = 1'b1;
                mem_op_d      = grant[0] ? ic_op : dc_op;
                mem_address_d = grant[0] ? ic_address : dc_address;
                mem_data_in_d = grant[0] ? ic_data_in : dc_data_in;
                state_d       = WAIT;
            end
            WAIT: if (mem_data_ready) begin
                ic_data_out_d   = (owner_q == REQ_IC && mem_op_q == OP_READ) ? mem_data_out : ic_data_out_q;
                dc_data_out_d   = (owner_q == REQ_DC && mem_op_q == OP_READ) ? mem_data_out : dc_data_out_q;
                ic_data_ready_d = (owner_q == REQ_IC);
                dc_data_ready_d = (owner_q == REQ_DC);
                mem_enable_d    = 1'b0;
                state_d         = RELEASE;
            end
            RELEASE: if (!owner_en) begin
                ic_data_ready_d = 1'b0;
                dc_data_ready_d = 1'b0;
                mem_op_done_d   = 1'b1;
                last_d          = (owner_q == REQ_DC);
                state_d         = DONE;
            end
            default: begin
                mem_op_done_d = 1'b0;
                owner_d       = REQ_NONE;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            owner_q         <= REQ_NONE;
            last_q          <= 1'b0;
            mem_enable_q    <= 1'b0;
            mem_op_q        <= 1'b0;
            mem_address_q   <= '0;
            mem_data_in_q   <= '0;
            mem_op_done_q   <= 1'b0;
            ic_data_out_q   <= '0;
            dc_data_out_q   <= '0;
            ic_data_ready_q <= 1'b0;
            dc_data_ready_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_q          <= last_d;
            mem_enable_q    <= mem_enable_d;
            mem_op_q        <= mem_op_d;
            mem_address_q   <= mem_address_d;
            mem_data_in_q   <= mem_data_in_d;
            mem_op_done_q   <= mem_op_done_d;
            ic_data_out_q   <= ic_data_out_d;
            dc_data_out_q   <= dc_data_out_d;
            ic_data_ready_q <= ic_data_ready_d;
            dc_data_ready_q <= dc_data_ready_d;
        end
    end

    assign ic_in_use     = (owner_q == REQ_DC) && (state_q != IDLE);
    assign dc_in_use     = (owner_q == REQ_IC) && (state_q != IDLE);
    assign mem_enable    = mem_enable_q;
    assign mem_op        = mem_op_q;
    assign mem_address   = mem_address_q;
    assign mem_data_in   = mem_data_in_q;
    assign mem_op_done   = mem_op_done_q;
    assign ic_data_out   = ic_data_out_q;
    assign dc_data_out   = dc_data_out_q;
    assign ic_data_ready = ic_data_ready_q;
    assign dc_data_ready = dc_data_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level reference model driving random and directed traffic
module tb_mem_arbiter;
    logic         clk = 1'b0, reset = 1'b1;
    logic         ic_enable = 0, ic_op = 0, dc_enable = 0, dc_op = 0;
    logic [31:0]  ic_address = 0, dc_address = 0;
    logic [127:0] ic_data_in = 0, dc_data_in = 0;
    logic [127:0] ic_data_out, dc_data_out, mem_data_in;
    logic         ic_data_ready, ic_in_use, dc_data_ready, dc_in_use;
    logic         mem_enable, mem_op, mem_op_done;
    logic [31:0]  mem_address;
    logic         mem_data_ready = 0;
    logic [127:0] mem_data_out = 0;

    int           n_vec = 0, n_err = 0;
    bit           last_ic = 1'b1;
    logic [127:0] exp_ic_out = 0, exp_dc_out = 0;

    mem_arbiter #(.ADDRESS_WIDTH(32), .LINE_SIZE(128)) dut (
        .clk(clk), .reset(reset),
        .ic_enable(ic_enable), .ic_op(ic_op), .ic_address(ic_address), .ic_data_in(ic_data_in),
        .ic_data_out(ic_data_out), .ic_data_ready(ic_data_ready), .ic_in_use(ic_in_use),
        .dc_enable(dc_enable), .dc_op(dc_op), .dc_address(dc_address), .dc_data_in(dc_data_in),
        .dc_data_out(dc_data_out), .dc_data_ready(dc_data_ready), .dc_in_use(dc_in_use),
        .mem_enable(mem_enable), .mem_op(mem_op), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_op_done(mem_op_done), .mem_data_ready(mem_data_ready), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic raise_ic();
        if (!ic_enable) begin
            ic_enable = 1; ic_op = 1'($urandom_range(1)); ic_address = $urandom; ic_data_in = rnd128();
        end
    endtask

    task automatic raise_dc();
        if (!dc_enable) begin
            dc_enable = 1; dc_op = 1'($urandom_range(1)); dc_address = $urandom; dc_data_in = rnd128();
        end
    endtask

    task automatic check_outs(input string tag, input logic [127:0] ico, input logic [127:0] dco);
        check({tag, "_ic_out"}, ic_data_out, ico);
        check({tag, "_dc_out"}, dc_data_out, dco);
        check({tag, "_ic_rdy"}, ic_data_ready, 0);
        check({tag, "_dc_rdy"}, dc_data_ready, 0);
        check({tag, "_ic_use"}, ic_in_use, 0);
        check({tag, "_dc_use"}, dc_in_use, 0);
        check({tag, "_men"}, mem_enable, 0);
        check({tag, "_mdone"}, mem_op_done, 0);
    endtask

    // One arbitrated transaction from grant to the return to IDLE
    task automatic txn(input int lat, input bit early, input bit late, input int hold, input logic [127:0] rd);
        bit           win_ic;
        logic         op;
        logic [31:0]  a;
        logic [127:0] d;
        win_ic = ic_enable && (!dc_enable || !last_ic);
        op = win_ic ? ic_op : dc_op;
        a  = win_ic ? ic_address : dc_address;
        d  = win_ic ? ic_data_in : dc_data_in;
        cyc();
        check("grant_en", mem_enable, 1);
        check("grant_op", mem_op, op);
        check("grant_addr", mem_address, a);
        check("grant_wdata", mem_data_in, d);
        check("grant_ic_use", ic_in_use, !win_ic);
        check("grant_dc_use", dc_in_use, win_ic);
        if (early) begin
            if (win_ic) ic_enable = 0; else dc_enable = 0;
        end
        if (late) begin
            if (win_ic) raise_dc(); else raise_ic();
        end
        repeat (lat) begin
            cyc();
            check("wait_en", mem_enable, 1);
            check("wait_op", mem_op, op);
            check("wait_addr", mem_address, a);
            check("wait_wdata", mem_data_in, d);
            check("wait_rdy", win_ic ? ic_data_ready : dc_data_ready, 0);
            check("wait_use", win_ic ? dc_in_use : ic_in_use, 1);
        end
        mem_data_ready = 1; mem_data_out = rd;
        cyc();
        mem_data_ready = 0; mem_data_out = rnd128();
        if (op == 1'b0) begin
            if (win_ic) exp_ic_out = rd; else exp_dc_out = rd;
        end
        check("ready_owner", win_ic ? ic_data_ready : dc_data_ready, 1);
        check("ready_other", win_ic ? dc_data_ready : ic_data_ready, 0);
        check("ready_ic_out", ic_data_out, exp_ic_out);
        check("ready_dc_out", dc_data_out, exp_dc_out);
        check("ready_men", mem_enable, 0);
        if (!early) begin
            repeat (hold) begin
                mem_data_ready = 1'($urandom_range(1));
                cyc();
                mem_data_ready = 0;
                check("hold_rdy", win_ic ? ic_data_ready : dc_data_ready, 1);
                check("hold_data", win_ic ? ic_data_out : dc_data_out, win_ic ? exp_ic_out : exp_dc_out);
                check("hold_done", mem_op_done, 0);
            end
            if (win_ic) ic_enable = 0; else dc_enable = 0;
        end
        cyc();
        check("drop_rdy", win_ic ? ic_data_ready : dc_data_ready, 0);
        check("op_done", mem_op_done, 1);
        check("done_use", win_ic ? dc_in_use : ic_in_use, 1);
        check("done_own_use", win_ic ? ic_in_use : dc_in_use, 0);
        cyc();
        check("op_done_clr", mem_op_done, 0);
        check("idle_ic_use", ic_in_use, 0);
        check("idle_dc_use", dc_in_use, 0);
        last_ic = win_ic;
    endtask

    initial begin
        repeat (2) cyc();
        check_outs("reset", 0, 0);
        reset = 0;
        cyc();
        check_outs("idle", 0, 0);

        dc_enable = 1; dc_op = 0; dc_address = 32'h0000_0040; dc_data_in = 0;
        txn(5, 0, 0, 2, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);

        ic_enable = 1; ic_op = 1; ic_address = 32'h0000_1000;
        ic_data_in = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
        txn(3, 0, 0, 1, rnd128());
        check("write_ic_out_zero", ic_data_out, 0);

        reset = 1; cyc(); reset = 0; last_ic = 1; exp_ic_out = 0; exp_dc_out = 0;
        raise_ic(); raise_dc();
        check("tie_first_dc", {ic_enable, dc_enable}, 2'b11);
        repeat (3) begin
            raise_ic(); raise_dc();
            txn($urandom_range(3), 0, 0, 0, rnd128());
        end
        while (ic_enable || dc_enable) txn(1, 0, 0, 0, rnd128());

        raise_dc();
        txn(4, 0, 1, 1, rnd128());
        txn(2, 0, 0, 0, rnd128());

        raise_ic();
        txn(3, 1, 0, 0, rnd128());

        raise_dc();
        cyc();
        repeat (2) cyc();
        reset = 1; dc_enable = 0;
        cyc();
        check_outs("midreset", 0, 0);
        reset = 0; last_ic = 1; exp_ic_out = 0; exp_dc_out = 0;
        raise_ic();
        txn(2, 0, 0, 1, rnd128());

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1)) raise_ic();
            if ($urandom_range(1)) raise_dc();
            if (!ic_enable && !dc_enable) raise_ic();
            txn($urandom_range(6), $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(2), rnd128());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
